// File: rtl/ser_pkg.sv
// Shared constants and state encoding for the result byte serializer.
// Build option SER_LAST_EN adds a word-boundary marker output on the byte stream.
package ser_pkg;

    localparam int DATA_W    = 256;
    localparam int BYTE_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AF_THRESH = 12;

    localparam int BYTES = DATA_W / BYTE_W;
    localparam int IDX_W = $clog2(BYTES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_word_fifo.sv
// First-word-fall-through word FIFO feeding the serializer shifter.
// The head word is always visible on rd_data while empty is low.
module ser_word_fifo
    import ser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              almost_full_q, almost_full_d;
    logic              push, pop;

    // Full is taken from the registered level, so a same-cycle pop never opens a write slot.
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    assign rd_data     = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign almost_full = almost_full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        almost_full_d = (level_d >= LVL_W'(AF_THRESH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Storage needs no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/result_byte_serializer.sv
// Buffers 256-bit result words and streams each one out LSB-first as 32 bytes.
// Define SER_LAST_EN to add dout_last, high on the final byte of every word.
module result_byte_serializer
    import ser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_vld,
    input  logic              ready,
    output logic [LVL_W-1:0]  word_level,
    output logic              almost_full,
    output logic              busy
`ifdef SER_LAST_EN
    ,
    output logic              dout_last
`endif
);

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              last_byte;

    ser_word_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_data     (din),
        .wr_en       (din_vld),
        .rd_en       (fifo_pop),
        .rd_data     (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (word_level),
        .almost_full (almost_full)
    );

    assign din_rdy   = !fifo_full;
    assign dout_vld  = (state_q == SHIFT);
    assign dout      = shift_q[BYTE_W-1:0];
    assign busy      = (state_q == SHIFT) || !fifo_empty;
    assign last_byte = (idx_q == IDX_W'(BYTES - 1));

`ifdef SER_LAST_EN
    assign dout_last = dout_vld && last_byte;
`endif

    // On the last accepted byte the next word is loaded directly, keeping the stream gapless.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_d  = fifo_head;
                    idx_d    = '0;
                    fifo_pop = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (ready) begin
                    if (!last_byte) begin
                        shift_d = shift_q >> BYTE_W;
                        idx_d   = idx_q + IDX_W'(1);
                    end else if (!fifo_empty) begin
                        shift_d  = fifo_head;
                        idx_d    = '0;
                        fifo_pop = 1'b1;
                    end else begin
                        shift_d = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule
